// File: rtl/vc_test_source_if.sv
// Val/rdy stream between vc_test_source (master) and the device under test (slave).
interface vc_test_source_if #(
    parameter int p_msg_nbits = 32
);
    logic [p_msg_nbits-1:0] out_msg;
    logic                   out_val;
    logic                   out_rdy;

    modport master (
        output out_msg,
        output out_val,
        input  out_rdy
    );

    modport slave (
        input  out_msg,
        input  out_val,
        output out_rdy
    );
endinterface

// File: rtl/vc_test_source.sv
// Preloaded message source that plays messages into a DUT over val/rdy with an idle gap before each.
// Define VC_TEST_SOURCE_RANDOM_DELAY_EN to draw each gap from an LFSR (0..p_delay) instead of a fixed p_delay.
module vc_test_source #(
    parameter int p_msg_nbits = 32,
    parameter int p_num_msgs  = 1024,
    parameter int p_delay     = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [$clog2(p_num_msgs)-1:0] load_idx,
    input  logic [p_msg_nbits-1:0]        load_msg,
    input  logic [$clog2(p_num_msgs):0]   num_msgs,
    input  logic                          go,
    vc_test_source_if.master              out_if,
    output logic                          done,
    output logic [$clog2(p_num_msgs):0]   sent
);

    localparam int AW = $clog2(p_num_msgs);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] NUM_MAX_C = NW'(p_num_msgs);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NW-1:0]          idx_q, idx_d;
    logic [NW-1:0]          n_q, n_d;
    logic [NW-1:0]          sent_q, sent_d;
    logic [15:0]            dcnt_q, dcnt_d;
    logic [15:0]            delay_s;
    logic                   xfer_s;
    logic                   load_ok_s;
    logic [p_msg_nbits-1:0] mem_q [p_num_msgs];

    // Requested count clamped to the memory depth.
    function automatic logic [NW-1:0] clamp_count(input logic [NW-1:0] req);
        clamp_count = (req > NUM_MAX_C) ? NUM_MAX_C : req;
    endfunction

`ifdef VC_TEST_SOURCE_RANDOM_DELAY_EN
    localparam logic [15:0] DMOD_C = 16'(p_delay + 1);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        lfsr_fb_s;

    assign lfsr_fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d    = {lfsr_q[14:0], lfsr_fb_s};
    assign delay_s   = lfsr_q % DMOD_C;

    // Free-running gap generator; reseeded on every reset so runs repeat exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign delay_s = 16'(p_delay);
`endif

    assign xfer_s    = (state_q == ST_SEND) && out_if.out_rdy;
    assign load_ok_s = load_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Message memory: written only while no run is in progress, never cleared.
    always_ff @(posedge clk) begin
        if (load_ok_s) begin
            mem_q[load_idx] <= load_msg;
        end
    end

    // Next-state and counter update for the run sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        sent_d  = sent_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    idx_d  = {NW{1'b0}};
                    sent_d = {NW{1'b0}};
                    n_d    = clamp_count(num_msgs);
                    if (n_d == {NW{1'b0}}) begin
                        state_d = ST_DONE;
                    end else if (delay_s == 16'd0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DELAY;
                        dcnt_d  = delay_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DELAY: begin
                dcnt_d = dcnt_q - 16'd1;
                // <=1 rather than ==1 so a zero count can never wedge the FSM.
                if (dcnt_q <= 16'd1) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_SEND: begin
                if (xfer_s) begin
                    idx_d  = idx_q + NW'(1);
                    sent_d = sent_q + NW'(1);
                    if (idx_q == (n_q - NW'(1))) begin
                        state_d = ST_DONE;
                    end else if (delay_s == 16'd0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DELAY;
                        dcnt_d  = delay_s;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {NW{1'b0}};
            n_q     <= {NW{1'b0}};
            sent_q  <= {NW{1'b0}};
            dcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            sent_q  <= sent_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign out_if.out_msg = mem_q[idx_q[AW-1:0]];
    assign out_if.out_val = (state_q == ST_SEND);
    assign done           = (state_q == ST_DONE);
    assign sent           = sent_q;

endmodule
